// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// Optional watchdog is enabled with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA_BUSY,
        INSTR_BUSY,
        DONE
    } arb_state_e;

    typedef enum logic {
        GRANT_INSTR,
        GRANT_DATA
    } grant_e;

    localparam int TIMEOUT_DEFAULT = 255;

    // Instruction fetches are always full-word accesses.
    localparam logic [2:0] CTRL_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter with a sticky timeout flag.
// Built into the arbiter only when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic busy_i,
    input  logic ready_i,
    output logic expire_o,
    output logic err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Fires in the TIMEOUT-th busy cycle that has seen no ready.
    assign expire_o = busy_i & ~ready_i & (cnt_q == CW'(TIMEOUT - 1));
    assign err_o    = err_q;

    always_comb begin
        cnt_d = '0;
        err_d = err_q | expire_o;
        if (busy_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Arbitrates one variable-latency memory port between fetch and load/store.
// Define MEM_ARB_TIMEOUT_EN to build in the busy-state watchdog.
module memory_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InstrReqF,
    input  logic [ADDR_W-1:0] PCF,
    input  logic              FlushF,
    output logic [DATA_W-1:0] InstrF,
    output logic              InstrValidF,
    input  logic              MemReqM,
    input  logic              MemWriteM,
    input  logic [2:0]        AddressingControlM,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              MemDoneM,
    output logic              StallF,
    output logic              StallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_ctrl,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              TimeoutErr
);

    arb_state_e        state_q, state_d;
    grant_e            gnt_q, gnt_d;
    grant_e            last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        ctrl_q, ctrl_d;
    logic              we_q, we_d;
    logic              flush_q, flush_d;

    logic              busy;
    logic              expire;
    logic              complete;
    logic              data_win;
    logic [DATA_W-1:0] resp;

    assign busy     = (state_q == DATA_BUSY) | (state_q == INSTR_BUSY);
    assign complete = busy & (mem_ready | expire);
    // An aborted access returns zero.
    assign resp     = mem_ready ? mem_rdata : '0;
    assign data_win = MemReqM & (~InstrReqF | (last_q == GRANT_INSTR));

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .busy_i   (busy),
        .ready_i  (mem_ready),
        .expire_o (expire),
        .err_o    (TimeoutErr)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign expire         = 1'b0;
    assign TimeoutErr     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        ctrl_d  = ctrl_q;
        we_d    = we_q;
        flush_d = flush_q;
        unique case (state_q)
            IDLE: begin
                if (data_win) begin
                    state_d = DATA_BUSY;
                    gnt_d   = GRANT_DATA;
                    addr_d  = ALUResultM;
                    wdata_d = WriteDataM;
                    ctrl_d  = AddressingControlM;
                    we_d    = MemWriteM;
                    flush_d = 1'b0;
                end else if (InstrReqF) begin
                    state_d = INSTR_BUSY;
                    gnt_d   = GRANT_INSTR;
                    addr_d  = PCF;
                    wdata_d = '0;
                    ctrl_d  = CTRL_WORD;
                    we_d    = 1'b0;
                    flush_d = 1'b0;
                end
            end
            DATA_BUSY: begin
                if (complete) begin
                    state_d = DONE;
                    last_d  = GRANT_DATA;
                    if (!we_q) begin
                        rdata_d = resp;
                    end
                end
            end
            INSTR_BUSY: begin
                if (FlushF) begin
                    flush_d = 1'b1;
                end
                if (complete) begin
                    state_d = DONE;
                    last_d  = GRANT_INSTR;
                    instr_d = resp;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= GRANT_INSTR;
            last_q  <= GRANT_INSTR;
            addr_q  <= '0;
            wdata_q <= '0;
            instr_q <= '0;
            rdata_q <= '0;
            ctrl_q  <= '0;
            we_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            we_q    <= we_d;
            flush_q <= flush_d;
        end
    end

    assign mem_req     = busy;
    assign mem_we      = busy & we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_ctrl    = ctrl_q;
    assign InstrF      = instr_q;
    assign ReadDataM   = rdata_q;
    assign MemDoneM    = (state_q == DONE) & (gnt_q == GRANT_DATA);
    assign InstrValidF = (state_q == DONE) & (gnt_q == GRANT_INSTR)
                         & ~flush_q & ~FlushF;
    assign StallM      = MemReqM & ~MemDoneM;
    assign StallF      = (InstrReqF & ~InstrValidF) | StallM;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench for memory_port_arbiter with a latency-programmable memory.
// Covers the watchdog path too when MEM_ARB_TIMEOUT_EN is defined.
module tb_memory_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        InstrReqF;
    logic [31:0] PCF;
    logic        FlushF;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic        MemReqM;
    logic        MemWriteM;
    logic [2:0]  AddressingControlM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemDoneM;
    logic        StallF;
    logic        StallM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_ctrl;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        TimeoutErr;

    typedef struct packed {
        logic        is_instr;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errors  = 0;
    int          lat     = 1;
    int          mcnt    = 0;
    logic [31:0] last_load;

    memory_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .InstrReqF          (InstrReqF),
        .PCF                (PCF),
        .FlushF             (FlushF),
        .InstrF             (InstrF),
        .InstrValidF        (InstrValidF),
        .MemReqM            (MemReqM),
        .MemWriteM          (MemWriteM),
        .AddressingControlM (AddressingControlM),
        .ALUResultM         (ALUResultM),
        .WriteDataM         (WriteDataM),
        .ReadDataM          (ReadDataM),
        .MemDoneM           (MemDoneM),
        .StallF             (StallF),
        .StallM             (StallM),
        .mem_req            (mem_req),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_ctrl           (mem_ctrl),
        .mem_ready          (mem_ready),
        .mem_rdata          (mem_rdata),
        .TimeoutErr         (TimeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory: ready in the lat-th cycle of mem_req; lat == 0 never answers.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mcnt++;
                if (lat != 0 && mcnt == lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = rd_fn(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hBAD0_BAD0;
                end
            end else begin
                mcnt      = 0;
                mem_ready = 1'b0;
            end
        end
    end

    // Completion monitor pops the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (InstrValidF || MemDoneM)) begin
                if (sb.size() == 0) begin
                    check("spurious_done", {InstrValidF, MemDoneM}, 0);
                end else begin
                    e = sb.pop_front();
                    check("done_kind", InstrValidF, e.is_instr);
                    check("done_data", e.is_instr ? InstrF : ReadDataM,
                          e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        InstrReqF = 1'b0;
        PCF = '0;
        FlushF = 1'b0;
        MemReqM = 1'b0;
        MemWriteM = 1'b0;
        AddressingControlM = '0;
        ALUResultM = '0;
        WriteDataM = '0;

        // Reset state
        cyc();
        cyc();
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_outs", {InstrValidF, MemDoneM, StallF, StallM, TimeoutErr}, 0);
        check("rst_instr", InstrF, 0);
        check("rst_rdata", ReadDataM, 0);
        rst_n = 1'b1;

        // Fetch only, zero-wait memory
        cyc();
        lat = 1; PCF = 32'h100; InstrReqF = 1'b1;
        sb.push_back('{1'b1, 32'h0050_0093});
        #1;
        check("f_c0_stallf", StallF, 1);
        check("f_c0_req", mem_req, 0);
        cyc(); #1;
        check("f_c1_req", mem_req, 1);
        check("f_c1_addr", mem_addr, 32'h100);
        check("f_c1_ctrl", mem_ctrl, 3'b010);
        check("f_c1_stallf", StallF, 1);
        cyc(); #1;
        check("f_c2_valid", InstrValidF, 1);
        check("f_c2_stallf", StallF, 0);
        cyc();
        InstrReqF = 1'b0;
        #1;
        check("f_c3_req", mem_req, 0);

        // Tie after reset: data first, then fetch
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        lat = 2;
        MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h2000;
        AddressingControlM = 3'b010;
        InstrReqF = 1'b1; PCF = 32'h104;
        last_load = rd_fn(32'h2000);
        sb.push_back('{1'b0, last_load});
        sb.push_back('{1'b1, rd_fn(32'h104)});
        #1;
        check("t1_c0_stallm", StallM, 1);
        cyc(); #1;
        check("t1_c1_addr", mem_addr, 32'h2000);
        check("t1_c1_we", mem_we, 0);
        check("t1_c1_stalls", {StallF, StallM}, 2'b11);
        cyc(); cyc(); #1;
        check("t1_c3_done", MemDoneM, 1);
        check("t1_c3_stallm", StallM, 0);
        cyc();
        MemReqM = 1'b0;
        #1;
        check("t1_c4_req", mem_req, 0);
        cyc(); #1;
        check("t1_c5_addr", mem_addr, 32'h104);
        cyc(); cyc(); #1;
        check("t1_c7_valid", InstrValidF, 1);
        cyc();
        InstrReqF = 1'b0;

        // Store with mem_ready in cycle 4
        cyc();
        lat = 4;
        MemReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = 32'h2004;
        WriteDataM = 32'hDEAD_BEEF; AddressingControlM = 3'b010;
        sb.push_back('{1'b0, last_load});
        for (int c = 1; c <= 4; c++) begin
            cyc(); #1;
            check("st_busy", {mem_req, mem_we}, 2'b11);
            check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("st_addr", mem_addr, 32'h2004);
        end
        cyc(); #1;
        check("st_c5_done", MemDoneM, 1);
        check("st_c5_rdata", ReadDataM, last_load);
        cyc();
        MemReqM = 1'b0; MemWriteM = 1'b0;

        // Tie after a data grant: fetch wins
        cyc();
        lat = 1;
        MemReqM = 1'b1; ALUResultM = 32'h3000;
        InstrReqF = 1'b1; PCF = 32'h300;
        sb.push_back('{1'b1, rd_fn(32'h300)});
        sb.push_back('{1'b0, rd_fn(32'h3000)});
        cyc(); #1;
        check("t2_c1_addr", mem_addr, 32'h300);
        cyc(); #1;
        check("t2_c2_valid", InstrValidF, 1);
        check("t2_c2_stallm", StallM, 1);
        cyc();
        InstrReqF = 1'b0;
        cyc(); #1;
        check("t2_c4_addr", mem_addr, 32'h3000);
        cyc(); #1;
        check("t2_c5_done", MemDoneM, 1);
        last_load = rd_fn(32'h3000);
        cyc();
        MemReqM = 1'b0;

        // Flush while busy
        cyc();
        lat = 3; InstrReqF = 1'b1; PCF = 32'h200;
        cyc();
        cyc();
        FlushF = 1'b1;
        cyc();
        FlushF = 1'b0;
        cyc(); #1;
        check("fl_c4_valid", InstrValidF, 0);
        check("fl_c4_stallf", StallF, 1);
        cyc();
        InstrReqF = 1'b0;
        #1;
        check("fl_c5_req", mem_req, 0);
        cyc(); #1;
        check("fl_c6_req", mem_req, 0);

        // Flush during the done cycle
        cyc();
        lat = 1; InstrReqF = 1'b1; PCF = 32'h240;
        cyc();
        cyc();
        FlushF = 1'b1;
        #1;
        check("fd_c2_valid", InstrValidF, 0);
        cyc();
        FlushF = 1'b0; InstrReqF = 1'b0;
        #1;
        check("fd_c3_req", mem_req, 0);

        // Reset in the middle of a data access
        cyc();
        lat = 0; MemReqM = 1'b1; ALUResultM = 32'h2008;
        cyc(); #1;
        check("rm_c1_req", mem_req, 1);
        cyc();
        rst_n = 1'b0; MemReqM = 1'b0;
        cyc(); #1;
        check("rm_req", mem_req, 0);
        check("rm_addr", mem_addr, 0);
        check("rm_instr", InstrF, 0);
        check("rm_rdata", ReadDataM, 0);
        check("rm_outs", {InstrValidF, MemDoneM, StallF, StallM, mem_we}, 0);
        rst_n = 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog abort after 8 busy cycles
        cyc();
        lat = 0; InstrReqF = 1'b1; PCF = 32'h400;
        sb.push_back('{1'b1, 32'h0});
        for (int c = 1; c <= 8; c++) begin
            cyc(); #1;
            check("to_busy", mem_req, 1);
            check("to_err_lo", TimeoutErr, 0);
        end
        cyc(); #1;
        check("to_valid", InstrValidF, 1);
        check("to_err", TimeoutErr, 1);
        cyc();
        InstrReqF = 1'b0;
        cyc(); cyc(); #1;
        check("to_sticky", TimeoutErr, 1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        check("to_clear", TimeoutErr, 0);
`endif

        cyc(); cyc();
        check("pending", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

- Shares one unified, variable-latency memory port between instruction fetch (F stage) and load/store access (M stage).
- Sequences each transaction with a request/ready handshake.
- Generates the stall signals that freeze the F-stage and M-stage pipeline registers, including the E→M register, until the access completes.
- Sits between the pipeline stage registers and the single-port memory model.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, watchdog limit in cycles (used only when the watchdog is compiled in)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- InstrReqF  in  1  fetch request
- PCF  in  ADDR_W  fetch address
- FlushF  in  1  discard the in-flight fetch result
- InstrF  out  DATA_W  fetched instruction
- InstrValidF  out  1  one-cycle pulse; InstrF is valid
- MemReqM  in  1  load/store request from M stage
- MemWriteM  in  1  1 = store
- AddressingControlM  in  3  byte/half/word and sign control, passed through
- ALUResultM  in  ADDR_W  data address
- WriteDataM  in  DATA_W  store data
- ReadDataM  out  DATA_W  load data
- MemDoneM  out  1  one-cycle pulse; data access complete
- StallF  out  1  freeze PC and F→D register
- StallM  out  1  freeze D→E and E→M registers; bubble into M→W
- mem_req, mem_we  out  1  memory request and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ctrl  out  3  memory access control
- mem_ready  in  1  memory handshake complete
- mem_rdata  in  DATA_W  memory read data
- TimeoutErr  out  1  sticky watchdog flag

## Operation
States: IDLE, DATA_BUSY, INSTR_BUSY, DONE.

IDLE:
- If only MemReqM is high → DATA_BUSY.
- If only InstrReqF is high → INSTR_BUSY.
- If both are high, the side not named by last_grant wins. last_grant resets to INSTR, so data wins the first tie.
- Request fields are latched into registers on the grant edge. mem_* outputs come only from these registers.

DATA_BUSY / INSTR_BUSY:
- mem_req = 1, holding the latched fields.
- On mem_ready = 1: capture mem_rdata, update last_grant, go to DONE.

DONE (one cycle):
- Pulse MemDoneM or InstrValidF, then return to IDLE. There is no back-to-back grant from DONE.

Stalls and flushes:
- StallM = MemReqM & ~MemDoneM.
- StallF = (InstrReqF & ~InstrValidF) | StallM.
- If FlushF is asserted during INSTR_BUSY or DONE, the memory transaction still completes, but InstrValidF stays 0 for that fetch.
- Stores: mem_we = 1, and ReadDataM holds its previous value.

Reset values:
- All outputs 0; InstrF and ReadDataM are 0.
- State = IDLE, last_grant = INSTR.
- mem_req falls on the first reset edge, even mid-transaction. The memory must tolerate abandonment.

## Timing
- Grant edge is cycle 0 (request seen in IDLE). mem_req is high from cycle 1.
- With mem_ready in cycle k ≥ 1, the done pulse occurs in cycle k+1.
- With a zero-wait memory (mem_ready in cycle 1), MemReqM in cycle 0 completes in cycle 2. StallM is high in cycles 0–1.
- mem_ready is ignored outside the BUSY states.
- Requests arriving while not IDLE are held by the pipeline stall and serviced after DONE.

## Configuration
Macro MEM_ARB_TIMEOUT_EN.

Defined:
- A cycle counter runs in the BUSY states.
- After TIMEOUT cycles without mem_ready: abort, go to DONE, return data 0, and set TimeoutErr until reset.

Undefined:
- No counter; TimeoutErr is tied to 0.
- BUSY waits indefinitely.

## Structure
- Package mem_arb_pkg: state enum (IDLE, DATA_BUSY, INSTR_BUSY, DONE), grant enum (GRANT_INSTR, GRANT_DATA), TIMEOUT_DEFAULT.
- Sub-module mem_arb_watchdog: the counter plus sticky flag, instantiated only under MEM_ARB_TIMEOUT_EN.

## Test plan
- Fetch only, PCF=0x100, mem_ready in cycle 1, rdata=0x00500093 → InstrF=0x00500093 and InstrValidF pulse in cycle 2; StallF high in cycles 0–1.
- Simultaneous MemReqM (load, 0x2000) and InstrReqF after reset → data granted first, ReadDataM=mem_rdata; fetch granted next, starting in the cycle after DONE.
- Store 0xDEADBEEF to 0x2004 with mem_ready delayed to cycle 4 → mem_we=1 and mem_wdata stable in cycles 1–4; MemDoneM in cycle 5; ReadDataM unchanged.
- FlushF during INSTR_BUSY → transaction completes; InstrValidF stays 0; state returns to IDLE.
- rst_n low in DATA_BUSY → mem_req=0 and state=IDLE after the edge; all outputs 0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, mem_ready never asserted → abort after 8 BUSY cycles; TimeoutErr=1 and sticky until reset.
